// File: rtl/iis_tdm_trans_recv.sv
// I2S / TDM master transceiver: derives sck/ws from mck, serialises CH-slot frames
// onto sdout and collects sdin into CH-slot frames, both sides with valid/ready.
module iis_tdm_trans_recv #(
    parameter int DW         = 24,
    parameter int SW         = 32,
    parameter int CH         = 2,
    parameter int MCK_TO_SCK = 8
) (
    input  logic             mck,
    input  logic             rst_n,
    input  logic             en,
    input  logic             fmt,
    output logic             sck,
    output logic             ws,
    output logic             sdout,
    input  logic             sdin,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [CH*DW-1:0] tx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [CH*DW-1:0] rx_data,
    output logic             tx_underrun,
    output logic             rx_overrun,
    output logic             frame_start
);
    localparam int FB  = CH * SW;
    localparam int BCW = $clog2(FB);
    localparam int SCW = $clog2(MCK_TO_SCK);
    localparam int DBW = CH * DW;
    localparam int IW  = $clog2(DBW);
    localparam logic [SCW-1:0] RISE_CNT = SCW'(MCK_TO_SCK / 2 - 1);
    localparam logic [SCW-1:0] FALL_CNT = SCW'(MCK_TO_SCK - 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(FB - 1);
    localparam logic [BCW-1:0] SW_BIT   = BCW'(SW);

    // I2S runs one sck behind the frame counter, so bit_cnt 0 carries the previous frame's last bit
    function automatic logic [BCW-1:0] serial_pos(input logic [BCW-1:0] b, input logic lj);
        logic [BCW-1:0] p;
        if (lj) begin
            p = b;
        end else if (b == {BCW{1'b0}}) begin
            p = LAST_BIT;
        end else begin
            p = b - BCW'(1);
        end
        return p;
    endfunction

    function automatic logic pos_is_data(input logic [BCW-1:0] p);
        return (int'(p) % SW) < DW;
    endfunction

    function automatic logic [IW-1:0] pos_index(input logic [BCW-1:0] p);
        int s;
        int k;
        s = int'(p) / SW;
        k = int'(p) % SW;
        return IW'(s * DW + DW - 1 - k);
    endfunction

    function automatic logic ws_of(input logic [BCW-1:0] b);
        return (CH == 2) ? (b >= SW_BIT) : (b == {BCW{1'b0}});
    endfunction

    logic [SCW-1:0] r_sck_cnt;
    logic [BCW-1:0] r_bit_cnt;
    logic           r_first;
    logic           r_sck, r_ws, r_sdout, r_fmt, r_frame_start;
    logic [DBW-1:0] r_tx_buf, r_tx_frame;
    logic           r_tx_ready, r_tx_underrun;
    logic [DBW-1:0] r_rx_shift, r_rx_data;
    logic           r_rx_armed, r_rx_done, r_rx_valid, r_rx_overrun;

    logic           w_rise, w_fall, w_start, w_fmt_eff, w_tx_xfer;
    logic [BCW-1:0] w_bit_next, w_p_next, w_p_cur;
    logic [DBW-1:0] w_load, w_tx_src;

    // Tick decode, next serial position and TX source selection
    always_comb begin
        w_rise    = en && (r_sck_cnt == RISE_CNT);
        w_fall    = en && (r_sck_cnt == FALL_CNT);
        w_start   = w_fall && (r_first || (r_bit_cnt == LAST_BIT));
        if (r_first || (r_bit_cnt == LAST_BIT)) begin
            w_bit_next = {BCW{1'b0}};
        end else begin
            w_bit_next = r_bit_cnt + BCW'(1);
        end
        w_fmt_eff = w_start ? fmt : r_fmt;
        w_p_next  = serial_pos(w_bit_next, w_fmt_eff);
        w_p_cur   = serial_pos(r_bit_cnt, r_fmt);
        w_load    = r_tx_ready ? {DBW{1'b0}} : r_tx_buf;
        // LJ frame start needs the incoming frame now; I2S still emits the old frame's last bit
        w_tx_src  = (w_start && w_fmt_eff) ? w_load : r_tx_frame;
        w_tx_xfer = tx_valid && r_tx_ready;
    end

    // Clock generation, frame counter, ws and format latch
    always_ff @(posedge mck or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_cnt     <= {SCW{1'b0}};
            r_bit_cnt     <= {BCW{1'b0}};
            r_first       <= 1'b1;
            r_sck         <= 1'b0;
            r_ws          <= 1'b0;
            r_frame_start <= 1'b0;
            r_fmt         <= 1'b1;
        end else if (!en) begin
            r_sck_cnt     <= {SCW{1'b0}};
            r_bit_cnt     <= {BCW{1'b0}};
            r_first       <= 1'b1;
            r_sck         <= 1'b0;
            r_ws          <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_sck_cnt     <= w_fall ? {SCW{1'b0}} : r_sck_cnt + SCW'(1);
            r_frame_start <= w_start;
            if (w_rise) begin
                r_sck <= 1'b1;
            end else if (w_fall) begin
                r_sck <= 1'b0;
            end
            if (w_fall) begin
                r_bit_cnt <= w_bit_next;
                r_first   <= 1'b0;
                r_ws      <= ws_of(w_bit_next);
            end
            if (w_start) begin
                r_fmt <= fmt;
            end
        end
    end

    // TX buffer handshake, frame load and serial output
    always_ff @(posedge mck or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_buf      <= {DBW{1'b0}};
            r_tx_ready    <= 1'b1;
            r_tx_frame    <= {DBW{1'b0}};
            r_tx_underrun <= 1'b0;
            r_sdout       <= 1'b0;
        end else begin
            r_tx_underrun <= w_start && r_tx_ready;
            if (w_tx_xfer) begin
                r_tx_buf   <= tx_data;
                r_tx_ready <= 1'b0;
            end else if (w_start) begin
                r_tx_ready <= 1'b1;
            end
            if (!en) begin
                r_tx_frame <= {DBW{1'b0}};
                r_sdout    <= 1'b0;
            end else begin
                if (w_start) begin
                    r_tx_frame <= w_load;
                end
                if (w_fall) begin
                    r_sdout <= pos_is_data(w_p_next) ? w_tx_src[pos_index(w_p_next)] : 1'b0;
                end
            end
        end
    end

    // RX sampling; a frame only completes if its first bit was captured after enable
    always_ff @(posedge mck or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_shift <= {DBW{1'b0}};
            r_rx_armed <= 1'b0;
            r_rx_done  <= 1'b0;
        end else if (!en) begin
            r_rx_armed <= 1'b0;
            r_rx_done  <= 1'b0;
        end else begin
            r_rx_done <= w_rise && !r_first && r_rx_armed && (w_p_cur == LAST_BIT);
            if (w_rise && !r_first) begin
                if (pos_is_data(w_p_cur)) begin
                    r_rx_shift[pos_index(w_p_cur)] <= sdin;
                end
                if (w_p_cur == {BCW{1'b0}}) begin
                    r_rx_armed <= 1'b1;
                end else if (w_p_cur == LAST_BIT) begin
                    r_rx_armed <= 1'b0;
                end
            end
        end
    end

    // RX output register, valid handshake and overrun detection
    always_ff @(posedge mck or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data    <= {DBW{1'b0}};
            r_rx_valid   <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else begin
            r_rx_overrun <= r_rx_done && r_rx_valid && !rx_ready;
            if (r_rx_done) begin
                r_rx_data  <= r_rx_shift;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign sck         = r_sck;
    assign ws          = r_ws;
    assign sdout       = r_sdout;
    assign tx_ready    = r_tx_ready;
    assign rx_valid    = r_rx_valid;
    assign rx_data     = r_rx_data;
    assign tx_underrun = r_tx_underrun;
    assign rx_overrun  = r_rx_overrun;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_iis_tdm_trans_recv.sv
// Directed bench: default 2x24/32 transceiver (instance A) and a 4x16/16 TDM
// instance (B), both with sdout looped back to sdin.
module tb_iis_tdm_trans_recv;
    logic mck = 1'b0;
    always #5 mck = ~mck;

    logic        a_rst_n, a_en, a_fmt, a_sck, a_ws, a_sdout, a_sdin, a_tx_valid, a_tx_ready;
    logic        a_rx_valid, a_rx_ready, a_tx_underrun, a_rx_overrun, a_frame_start;
    logic [47:0] a_tx_data, a_rx_data;
    logic        b_rst_n, b_en, b_fmt, b_sck, b_ws, b_sdout, b_sdin, b_tx_valid, b_tx_ready;
    logic        b_rx_valid, b_rx_ready, b_tx_underrun, b_rx_overrun, b_frame_start;
    logic [63:0] b_tx_data, b_rx_data;

    assign a_sdin = a_sdout;
    assign b_sdin = b_sdout;

    iis_tdm_trans_recv u_a (
        .mck(mck), .rst_n(a_rst_n), .en(a_en), .fmt(a_fmt), .sck(a_sck), .ws(a_ws),
        .sdout(a_sdout), .sdin(a_sdin), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
        .tx_data(a_tx_data), .rx_valid(a_rx_valid), .rx_ready(a_rx_ready), .rx_data(a_rx_data),
        .tx_underrun(a_tx_underrun), .rx_overrun(a_rx_overrun), .frame_start(a_frame_start)
    );

    iis_tdm_trans_recv #(.DW(16), .SW(16), .CH(4), .MCK_TO_SCK(4)) u_b (
        .mck(mck), .rst_n(b_rst_n), .en(b_en), .fmt(b_fmt), .sck(b_sck), .ws(b_ws),
        .sdout(b_sdout), .sdin(b_sdin), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
        .tx_data(b_tx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready), .rx_data(b_rx_data),
        .tx_underrun(b_tx_underrun), .rx_overrun(b_rx_overrun), .frame_start(b_frame_start)
    );

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    logic a_sck_q = 1'b0, a_ws_q = 1'b0, b_sck_q = 1'b0, b_ws_q = 1'b0;
    int a_sck_last = 0, a_sck_prev = 0, a_ws_last = 0, a_ws_prev = 0;
    int b_sck_last = 0, b_sck_prev = 0, b_ws_last = 0, b_ws_prev = 0, b_ws_run = 0, b_ws_len = 0;
    int a_fs_cnt = 0, a_ur_cnt = 0, a_ov_cnt = 0, a_ones = 0, a_rx_cnt = 0, b_rx_cnt = 0;
    logic [47:0] a_rx_last = 48'd0;
    logic [63:0] b_rx_last = 64'd0;

    // Edge timing, pulse counters and rx consumption for both instances
    always @(posedge mck) begin
        cyc     <= cyc + 1;
        a_sck_q <= a_sck;
        a_ws_q  <= a_ws;
        b_sck_q <= b_sck;
        b_ws_q  <= b_ws;
        if (a_sck && !a_sck_q) begin a_sck_prev <= a_sck_last; a_sck_last <= cyc; end
        if (a_ws && !a_ws_q)   begin a_ws_prev  <= a_ws_last;  a_ws_last  <= cyc; end
        if (b_sck && !b_sck_q) begin b_sck_prev <= b_sck_last; b_sck_last <= cyc; end
        if (b_ws && !b_ws_q)   begin b_ws_prev  <= b_ws_last;  b_ws_last  <= cyc; end
        if (b_ws) b_ws_run <= b_ws_run + 1;
        else begin
            if (b_ws_run != 0) b_ws_len <= b_ws_run;
            b_ws_run <= 0;
        end
        if (a_frame_start) a_fs_cnt <= a_fs_cnt + 1;
        if (a_tx_underrun) a_ur_cnt <= a_ur_cnt + 1;
        if (a_rx_overrun)  a_ov_cnt <= a_ov_cnt + 1;
        if (a_sdout)       a_ones   <= a_ones + 1;
        if (a_rx_valid && a_rx_ready) begin a_rx_cnt <= a_rx_cnt + 1; a_rx_last <= a_rx_data; end
        if (b_rx_valid && b_rx_ready) begin b_rx_cnt <= b_rx_cnt + 1; b_rx_last <= b_rx_data; end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_fs_a(input int budget);
        int n = 0;
        do begin @(negedge mck); n++; end while (!a_frame_start && n < budget);
        chk("a_fs_wait", 64'(a_frame_start), 64'd1);
    endtask

    task automatic wait_fs_b(input int budget);
        int n = 0;
        do begin @(negedge mck); n++; end while (!b_frame_start && n < budget);
        chk("b_fs_wait", 64'(b_frame_start), 64'd1);
    endtask

    task automatic wait_rx_a(input int target, input int budget);
        int n = 0;
        while (a_rx_cnt < target && n < budget) begin @(negedge mck); n++; end
        chk("a_rx_wait", 64'(a_rx_cnt >= target), 64'd1);
    endtask

    task automatic wait_rx_b(input int target, input int budget);
        int n = 0;
        while (b_rx_cnt < target && n < budget) begin @(negedge mck); n++; end
        chk("b_rx_wait", 64'(b_rx_cnt >= target), 64'd1);
    endtask

    // Samples one A frame of sdout (mid sck-high), first bit in v[63]; fmt is changed mid-frame
    task automatic cap_a(output logic [63:0] v, input logic mid_fmt);
        v = 64'd0;
        wait_fs_a(600);
        for (int i = 0; i < 64; i++) begin
            repeat (4) @(negedge mck);
            if (i == 10) a_fmt = mid_fmt;
            v = {v[62:0], a_sdout};
            if (i < 63) repeat (4) @(negedge mck);
        end
    endtask

    localparam logic [47:0] X  = {24'h123456, 24'hABCDEF};
    localparam logic [47:0] Y  = {24'h0F1E2D, 24'h800001};
    localparam logic [47:0] Z  = {24'h555AAA, 24'h13579B};
    localparam logic [63:0] PX = 64'hABCDEF00_12345600;
    localparam logic [63:0] PY = 64'h80000100_0F1E2D00;
    localparam logic [63:0] W1 = 64'hCAFE_0123_8001_7FFE;
    localparam logic [63:0] W2 = 64'h0F0F_F0F0_3C3C_C3C3;
    localparam logic [63:0] W3 = 64'h5555_AAAA_F00D_1234;

    initial begin
        logic [63:0] v;
        int rx0, u0, f0, o0, ones0;
        a_rst_n = 1'b0; a_en = 1'b0; a_fmt = 1'b1; a_tx_valid = 1'b0; a_tx_data = 48'd0; a_rx_ready = 1'b1;
        b_rst_n = 1'b0; b_en = 1'b0; b_fmt = 1'b1; b_tx_valid = 1'b0; b_tx_data = 64'd0; b_rx_ready = 1'b1;
        repeat (5) @(negedge mck);
        chk("a_rst_pins", 64'({a_sck, a_ws, a_sdout, a_frame_start, a_tx_underrun, a_rx_overrun}), 64'd0);
        chk("a_rst_tx_ready", 64'(a_tx_ready), 64'd1);
        chk("a_rst_rx_valid", 64'(a_rx_valid), 64'd0);
        chk("a_rst_rx_data", 64'(a_rx_data), 64'd0);

        a_rst_n = 1'b1; a_en = 1'b1;
        repeat (1100) @(negedge mck);
        chk("a_sck_period", 64'(a_sck_last - a_sck_prev), 64'd8);
        chk("a_ws_period", 64'(a_ws_last - a_ws_prev), 64'd512);

        // Left-justified loopback
        wait_fs_a(600);
        a_tx_valid = 1'b1; a_tx_data = X;
        @(negedge mck);
        a_tx_valid = 1'b0;
        chk("a_tx_ready_low", 64'(a_tx_ready), 64'd0);
        rx0 = a_rx_cnt;
        cap_a(v, 1'b1);
        chk("a_lj_serial", v, PX);
        wait_rx_a(rx0 + 2, 40);
        chk("a_lj_rx_data", 64'(a_rx_last), 64'(X));
        chk("a_tx_ready_back", 64'(a_tx_ready), 64'd1);

        // fmt switched mid-frame must not disturb the current LJ frame
        a_tx_valid = 1'b1; a_tx_data = Y;
        @(negedge mck);
        a_tx_valid = 1'b0;
        cap_a(v, 1'b0);
        chk("a_fmt_mid_frame", v, PY);
        a_tx_valid = 1'b1; a_tx_data = X;
        @(negedge mck);
        a_tx_valid = 1'b0;
        cap_a(v, 1'b0);
        chk("a_i2s_serial", v, {PY[0], PX[63:1]});
        chk("a_i2s_msb_delay", 64'({v[63], v[62]}), 64'd1);
        rx0 = a_rx_cnt;
        wait_rx_a(rx0 + 1, 40);
        chk("a_i2s_rx_data", 64'(a_rx_last), 64'(X));

        // Underrun over three empty frames
        wait_fs_a(600);
        u0 = a_ur_cnt; f0 = a_fs_cnt; ones0 = a_ones;
        repeat (3) wait_fs_a(600);
        chk("a_underrun_cnt", 64'(a_ur_cnt - u0), 64'd3);
        chk("a_fs_cnt", 64'(a_fs_cnt - f0), 64'd3);
        chk("a_sdout_zero", 64'(a_ones - ones0), 64'd0);
        a_tx_valid = 1'b1; a_tx_data = Z;
        @(negedge mck);
        a_tx_valid = 1'b0;
        chk("a_tx_ready_after_offer", 64'(a_tx_ready), 64'd0);
        repeat (400) @(negedge mck);
        chk("a_tx_ready_held", 64'(a_tx_ready), 64'd0);
        wait_fs_a(600);
        chk("a_tx_ready_at_fs", 64'(a_tx_ready), 64'd1);

        // Overrun: two completions with rx_ready low
        a_rx_ready = 1'b0;
        o0 = a_ov_cnt;
        wait_fs_a(600);
        repeat (20) @(negedge mck);
        chk("a_overrun_cnt", 64'(a_ov_cnt - o0), 64'd1);
        chk("a_overrun_valid", 64'(a_rx_valid), 64'd1);
        chk("a_overrun_data", 64'(a_rx_data), 64'(Z));
        a_rx_ready = 1'b1;
        @(negedge mck);
        chk("a_rx_valid_clear", 64'(a_rx_valid), 64'd0);
        a_en = 1'b0;
        @(negedge mck);
        chk("a_en_off_pins", 64'({a_sck, a_ws, a_sdout}), 64'd0);
        chk("a_en_off_tx_ready", 64'(a_tx_ready), 64'd1);

        // TDM instance: ws shape, loopback, async reset mid-frame
        b_rst_n = 1'b1; b_en = 1'b1;
        repeat (600) @(negedge mck);
        chk("b_sck_period", 64'(b_sck_last - b_sck_prev), 64'd4);
        chk("b_ws_period", 64'(b_ws_last - b_ws_prev), 64'd256);
        chk("b_ws_len", 64'(b_ws_len), 64'd4);
        wait_fs_b(300);
        b_tx_valid = 1'b1; b_tx_data = W1;
        @(negedge mck);
        b_tx_valid = 1'b0;
        rx0 = b_rx_cnt;
        wait_rx_b(rx0 + 2, 700);
        chk("b_loop_data", b_rx_last, W1);
        b_rx_ready = 1'b0;
        wait_fs_b(300);
        wait_fs_b(300);
        b_tx_valid = 1'b1; b_tx_data = W2;
        @(negedge mck);
        b_tx_valid = 1'b0;
        repeat (37 * 4 + 1) @(negedge mck);
        chk("b_pre_rst_state", 64'({b_sck, b_tx_ready, b_rx_valid}), 64'b101);
        b_rst_n = 1'b0;
        #1;
        chk("b_rst_pins", 64'({b_sck, b_ws, b_sdout, b_frame_start, b_tx_underrun, b_rx_overrun}), 64'd0);
        chk("b_rst_handshake", 64'({b_tx_ready, b_rx_valid}), 64'b10);
        chk("b_rst_rx_data", b_rx_data, 64'd0);
        @(negedge mck);
        b_rst_n = 1'b1; b_rx_ready = 1'b1;
        wait_fs_b(300);
        b_tx_valid = 1'b1; b_tx_data = W3;
        @(negedge mck);
        b_tx_valid = 1'b0;
        rx0 = b_rx_cnt;
        wait_rx_b(rx0 + 2, 700);
        chk("b_restart_data", b_rx_last, W3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/iis_tdm_trans_recv.md
Name: iis_tdm_trans_recv

Overview:
Parametrised I2S/TDM master transceiver. It generates sck/ws from mck, serialises CH channels per frame onto sdout, and deserialises sdin into CH-channel frames. Both data paths use valid/ready handshakes. It is the successor of the fixed 2x32-bit transceiver and adds configurable width, channel count, left-justified or I2S framing, a TX frame buffer, and underrun/overrun flags. It sits between the codec pins and the equalizer datapath.

Parameters:
DW, 24, sample width in bits (1..SW)
SW, 32, slot width in sck periods (>=DW)
CH, 2, channels (slots) per frame (>=2)
MCK_TO_SCK, 8, mck cycles per sck period (even, >=2)

Ports:
mck  in  1  system/master clock
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; 0 holds clocks idle
fmt  in  1  0=I2S (data one sck after ws edge), 1=left-justified
sck  out  1  serial bit clock, registered
ws  out  1  word select / frame sync, registered
sdout  out  1  serial data out, registered, changes on sck fall
sdin  in  1  serial data in, sampled on sck rise
tx_valid  in  1  tx frame offered
tx_ready  out  1  tx buffer empty
tx_data  in  CH*DW  channel c at [c*DW +: DW], channel 0 = first slot
rx_valid  out  1  rx frame available
rx_ready  in  1  rx consumer ready
rx_data  out  CH*DW  same layout as tx_data
tx_underrun  out  1  one-mck pulse: frame started with empty buffer
rx_overrun  out  1  one-mck pulse: unread rx frame overwritten
frame_start  out  1  one-mck pulse on the sck fall that starts a frame

Behaviour:
- Reset (async assert, sync release): all counters 0; sck=0, ws=0, sdout=0; tx_ready=1; rx_valid=0; rx_data=0; pulses 0; fmt latch=1.
- sck_cnt counts 0..MCK_TO_SCK-1 while en=1.
  - rise_tick: sck_cnt==MCK_TO_SCK/2-1. sck<=1.
  - fall_tick: sck_cnt==MCK_TO_SCK-1. sck<=0.
- bit_cnt counts 0..CH*SW-1 and advances on fall_tick. Wrap to 0 is the frame start: frame_start pulses and fmt is latched. A fmt change mid-frame takes effect at the next frame.
- ws on CH==2: ws=0 while bit_cnt<SW, otherwise 1 (50% duty).
- ws on CH>2: ws=1 only while bit_cnt==0 (one sck per frame).
- Serial position p = bit_cnt in LJ mode; p = bit_cnt-1 mod CH*SW in I2S mode.
  - Slot s = p/SW, bit k = p%SW.
  - k<DW: bit = sample MSB-first. k>=DW: bit = 0.
  - RX uses the same mapping, so sample bits beyond DW are ignored.
- TX path:
  - Handshake: transfer occurs when tx_valid && tx_ready. Data goes to a one-frame buffer; tx_ready<=0.
  - At frame start, the shift register loads from the buffer and tx_ready<=1.
  - If the buffer is empty at frame start, load zeros and pulse tx_underrun.
  - Transfer and frame start in the same cycle: the old buffer content is loaded, the new data enters the buffer, and tx_ready stays 0.
  - In I2S mode the last LSB of a frame is emitted in bit_cnt 0 of the next frame, from a held bit.
- RX path:
  - sdin is shifted on rise_tick into per-slot registers.
  - When the last bit of the frame has been sampled (the rise_tick where p==CH*SW-1), the frame is copied to rx_data and rx_valid<=1 on the next mck edge.
  - rx_valid clears on rx_valid && rx_ready.
  - If rx_valid=1 and rx_ready=0 at copy time: overwrite, keep rx_valid=1, pulse rx_overrun.
  - Copy with simultaneous consume: new frame, rx_valid stays 1, no overrun.
- en=0: sck_cnt and bit_cnt reset to 0; sck, ws, sdout = 0; partial RX frame discarded.
  - TX buffer and rx_data are retained and handshakes still operate.
  - en 0->1 starts a fresh frame at bit_cnt 0, and frame_start pulses on the first fall_tick.
- Reset mid-frame: immediate return to reset values; buffered frames lost; no pulses.
- Arithmetic: counters use $clog2 widths sized to hold the maximum count; no overflow past terminal counts.

Test Plan:
1. Reset/idle. Hold rst_n=0 and en=0 -> sck=ws=sdout=0, tx_ready=1, rx_valid=0. Release with en=1 -> sck period 8 mck, ws period 512 mck (defaults).
2. Loopback sdout->sdin, defaults, fmt=1. Send tx_data={24'h123456,24'hABCDEF} -> rx_data returns the same value on the second rx_valid after send. Slot bits 24..31 are 0 on sdout.
3. fmt=0 check. ws falls -> MSB of 24'hABCDEF appears on sdout at the fall_tick one sck later. Switching fmt mid-frame -> applied only after the next frame_start.
4. Underrun. tx_valid=0 for 3 frames -> sdout constantly 0, tx_underrun pulses exactly 3 times, once per frame_start. Then offer 1 frame -> tx_ready low until the next frame_start.
5. Overrun. rx_ready=0 across 2 frame completions -> one rx_overrun pulse, rx_data = latest frame. Raise rx_ready -> rx_valid clears next cycle.
6. CH=4, SW=16, DW=16, MCK_TO_SCK=4. ws high for 4 mck once per 256 mck; 4-channel loopback intact. Assert rst_n low at bit_cnt=37 -> all outputs at reset values within the same cycle, clean restart afterwards.
